rle_expander: RTL

Run-length expander: the inverse of the consecutive-repeat counter. It accepts (value, repeat count) pairs and replays each value on a streaming output for count+1 beats, tagging each beat with its index within the run. It sits downstream of a run-length encoder/channel and regenerates the original sample stream. A one-entry pending buffer lets consecutive runs stream with no idle beat between them.

---
 rtl/rle_pkg.sv | 12 +
 rtl/rle_hold_reg.sv | 26 ++
 rtl/rle_expander.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared constants and state encoding for the run-length expander.
package rle_pkg;

    localparam int RLE_DATA_W = 8;
    localparam int RLE_CNT_W  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } rle_state_t;

endpackage

// File: rtl/rle_hold_reg.sv
// One-entry holding register with a full flag; load takes priority over clear.
module rle_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (load) begin
            full <= 1'b1;
            q    <= d;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/rle_expander.sv
// Replays each accepted (value, count) pair for count+1 beats, tagging beats with their index.
//   state | meaning
//   IDLE  | no active run, outputs hold last values
//   EMIT  | active run in cur_val/cur_cnt/idx is driven on the output
module rle_expander
    import rle_pkg::*;
#(
    parameter int DATA_W = RLE_DATA_W,
    parameter int CNT_W  = RLE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_val,
    input  logic [CNT_W-1:0]  in_cnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val,
    output logic [CNT_W-1:0]  out_idx,
    output logic              out_last
);

    rle_state_t state, state_nxt;

    logic [DATA_W-1:0]       cur_val;
    logic [CNT_W-1:0]        cur_cnt;
    logic [CNT_W-1:0]        idx;
    logic                    last_q;

    logic                    pend_full;
    logic [DATA_W+CNT_W-1:0] pend_q;
    logic [DATA_W-1:0]       pend_val;
    logic [CNT_W-1:0]        pend_cnt;

    logic                    accept;
    logic                    fire;
    logic                    load_cur;
    logic                    load_from_pend;
    logic                    idx_inc;
    logic                    pend_load;
    logic                    pend_clear;
    logic [DATA_W-1:0]       nxt_val;
    logic [CNT_W-1:0]        nxt_cnt;
    logic [CNT_W-1:0]        idx_plus;

    assign {pend_val, pend_cnt} = pend_q;

    // in_ready depends only on registered state so out_ready never reaches it
    assign in_ready = !pend_full && !rst;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;
    assign nxt_val  = load_from_pend ? pend_val : in_val;
    assign nxt_cnt  = load_from_pend ? pend_cnt : in_cnt;
    assign idx_plus = idx + CNT_W'(1);

    rle_hold_reg #(
        .W (DATA_W + CNT_W)
    ) u_pend (
        .clk   (clk),
        .rst   (rst),
        .load  (pend_load),
        .clear (pend_clear),
        .d     ({in_val, in_cnt}),
        .q     (pend_q),
        .full  (pend_full)
    );

    always_comb begin
        state_nxt      = state;
        load_cur       = 1'b0;
        load_from_pend = 1'b0;
        idx_inc        = 1'b0;
        pend_load      = 1'b0;
        pend_clear     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EMIT;
                    load_cur  = 1'b1;
                end
            end
            EMIT: begin
                if (fire && last_q) begin
                    if (pend_full) begin
                        load_cur       = 1'b1;
                        load_from_pend = 1'b1;
                        pend_clear     = 1'b1;
                    end else if (accept) begin
                        load_cur = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    idx_inc   = fire;
                    pend_load = accept;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur_val <= '0;
            cur_cnt <= '0;
            idx     <= '0;
            last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_cur) begin
                cur_val <= nxt_val;
                cur_cnt <= nxt_cnt;
                idx     <= '0;
                last_q  <= (nxt_cnt == '0);
            end else if (idx_inc) begin
                idx    <= idx_plus;
                last_q <= (idx_plus == cur_cnt);
            end
        end
    end

    assign out_valid = (state == EMIT);
    assign out_val   = cur_val;
    assign out_idx   = idx;
    assign out_last  = last_q;

endmodule
